// File: rtl/gf2_matvec_seq.sv
// -----------------------------------------------------------------------------
// gf2_matvec_seq
// Sequential GF(2) matrix-vector multiplier: y = A * x, one row per clock.
// Each result bit is the XOR-reduction of (row r AND x).
//
// Parameters:
//   N   - vector length / row width (columns of A), N >= 1
//   M   - number of rows / result width, M >= 1
//   CW  - row-counter width, $clog2(M+1) (derived, not overridable)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand pair presented
//   in_ready   out  block can accept operands (state == IDLE)
//   in_mat     in   M*N matrix, row r at [r*N +: N], column j at bit r*N+j
//   in_vec     in   N-bit vector, element j at bit j
//   out_valid  out  result available (state == DONE)
//   out_ready  in   consumer accepts result
//   out_vec    out  M-bit result, bit r = dot(row r, vector) mod 2
//   busy       out  high while rows are being computed
//   out_weight out  Hamming weight of out_vec (only with MATVEC_WEIGHT_EN)
//
// Optional feature macro: MATVEC_WEIGHT_EN
// -----------------------------------------------------------------------------
module gf2_matvec_seq #(
    parameter  int unsigned N  = 4,
    parameter  int unsigned M  = 4,
    localparam int unsigned CW = $clog2(M + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M*N-1:0] in_mat,
    input  logic [N-1:0]   in_vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_vec,
    output logic           busy
`ifdef MATVEC_WEIGHT_EN
    ,
    output logic [CW-1:0]  out_weight
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [M*N-1:0] mat_q,   mat_d;
    logic [N-1:0]   vec_q,   vec_d;
    logic [M-1:0]   res_q,   res_d;
    logic [CW-1:0]  row_q,   row_d;
    logic           row_bit_c;

`ifdef MATVEC_WEIGHT_EN
    logic [CW-1:0]  wt_q,    wt_d;
`endif

    // Dot product of the currently selected row with the latched vector.
    always_comb begin
        row_bit_c = 1'b0;
        for (int r = 0; r < int'(M); r++) begin
            if (row_q == CW'(r)) begin
                row_bit_c = ^(mat_q[r*N +: N] & vec_q);
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        vec_d   = vec_q;
        res_d   = res_q;
        row_d   = row_q;
`ifdef MATVEC_WEIGHT_EN
        wt_d    = wt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mat_d   = in_mat;
                    vec_d   = in_vec;
                    res_d   = '0;
                    row_d   = '0;
`ifdef MATVEC_WEIGHT_EN
                    wt_d    = '0;
`endif
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int r = 0; r < int'(M); r++) begin
                    if (row_q == CW'(r)) begin
                        res_d[r] = row_bit_c;
                    end
                end
`ifdef MATVEC_WEIGHT_EN
                if (row_bit_c) begin
                    wt_d = wt_q + CW'(1);
                end
`endif
                // Counter parks at M-1 instead of wrapping.
                if (row_q == CW'(M - 1)) begin
                    state_d = S_DONE;
                end else begin
                    row_d = row_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mat_q   <= '0;
            vec_q   <= '0;
            res_q   <= '0;
            row_q   <= '0;
`ifdef MATVEC_WEIGHT_EN
            wt_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
            row_q   <= row_d;
`ifdef MATVEC_WEIGHT_EN
            wt_q    <= wt_d;
`endif
        end
    end

    // Handshake/status flags are decodes of the state register.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out_vec   = res_q;
`ifdef MATVEC_WEIGHT_EN
    assign out_weight = wt_q;
`endif

endmodule
